// File: rtl/dds_seq_pkg.sv
// Shared definitions for the DDS frequency-hop sequencer.
//   - default sizing for the hop table and counters
//   - sequencer state encoding
package dds_seq_pkg;

  localparam int unsigned DEPTH_DEF         = 8;
  localparam int unsigned SETTLE_CYCLES_DEF = 16;
  localparam int unsigned PINC_W_DEF        = 32;
  localparam int unsigned DWELL_W_DEF       = 24;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCfg,
    StSettle,
    StDwell,
    StDone
  } seq_state_e;

endpackage

// File: rtl/dds_hop_table.sv
// Hop table: DEPTH entries of {pinc1, pinc2, dwell}.
// Ports:
//   GCLK, reset          clock, async active-low reset (clears every entry)
//   we, waddr            write strobe and address
//   pinc1, pinc2, dwell  write data
//   re, raddr            read enable and address; data is registered
//   rd_pinc1/2, rd_dwell registered read data, held until the next read
module dds_hop_table #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PINC_W  = 32,
  parameter int unsigned DWELL_W = 24
) (
  input  logic                     GCLK,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [PINC_W-1:0]        pinc1,
  input  logic [PINC_W-1:0]        pinc2,
  input  logic [DWELL_W-1:0]       dwell,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [PINC_W-1:0]        rd_pinc1,
  output logic [PINC_W-1:0]        rd_pinc2,
  output logic [DWELL_W-1:0]       rd_dwell
);

  localparam int unsigned EntW = 2 * PINC_W + DWELL_W;

  logic [EntW-1:0] mem_q [DEPTH];
  logic [EntW-1:0] rd_q;

  always_ff @(posedge GCLK or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= {pinc1, pinc2, dwell};
    end
  end

  // Read register captures the pre-write contents when read and write collide.
  always_ff @(posedge GCLK or negedge reset) begin
    if (!reset) begin
      rd_q <= '0;
    end else if (re) begin
      rd_q <= mem_q[raddr];
    end
  end

  assign {rd_pinc1, rd_pinc2, rd_dwell} = rd_q;

endmodule

// File: rtl/dds_hop_sequencer.sv
// Frequency-hop sequencer for a dual-DDS source. Steps through hop-table entries:
// load entry, push both phase increments over AXI-stream style config channels,
// flush the DDS pipeline, then enable the combiner for the entry's dwell time.
// Ports:
//   GCLK, reset                     clock, async active-low reset
//   tbl_we/addr/pinc1/pinc2/dwell   hop-table write port (accepted in any state)
//   num_entries, loop_en            sequence length (sampled on start) and wrap mode
//   start, abort                    run request / stop request
//   cfg{1,2}_tdata/tvalid/tready    DDS phase-config channels
//   dds_valid                       combined DDS output valid
//   MODULE_ENA                      combiner enable (high only while dwelling)
//   busy, done, cur_idx             status
module dds_hop_sequencer
  import dds_seq_pkg::*;
#(
  parameter int unsigned DEPTH         = DEPTH_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned PINC_W        = PINC_W_DEF,
  parameter int unsigned DWELL_W       = DWELL_W_DEF
) (
  input  logic                     GCLK,
  input  logic                     reset,
  input  logic                     tbl_we,
  input  logic [$clog2(DEPTH)-1:0] tbl_addr,
  input  logic [PINC_W-1:0]        tbl_pinc1,
  input  logic [PINC_W-1:0]        tbl_pinc2,
  input  logic [DWELL_W-1:0]       tbl_dwell,
  input  logic [$clog2(DEPTH):0]   num_entries,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     abort,
  output logic [PINC_W-1:0]        cfg1_tdata,
  output logic                     cfg1_tvalid,
  input  logic                     cfg1_tready,
  output logic [PINC_W-1:0]        cfg2_tdata,
  output logic                     cfg2_tvalid,
  input  logic                     cfg2_tready,
  input  logic                     dds_valid,
  output logic                     MODULE_ENA,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] cur_idx
);

  localparam int unsigned IdxW    = $clog2(DEPTH);
  localparam int unsigned SetW    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [IdxW:0] MaxEntries = (IdxW + 1)'(DEPTH);

  seq_state_e          state_q, state_d;
  logic [IdxW-1:0]     cur_idx_q, cur_idx_d;
  logic [IdxW-1:0]     last_idx_q, last_idx_d;
  logic                tvalid1_q, tvalid1_d;
  logic                tvalid2_q, tvalid2_d;
  logic                abort_pend_q, abort_pend_d;
  logic [SetW-1:0]     settle_q, settle_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                rd_en;
  logic [DWELL_W-1:0]  rd_dwell;

  dds_hop_table #(
    .DEPTH   (DEPTH),
    .PINC_W  (PINC_W),
    .DWELL_W (DWELL_W)
  ) u_table (
    .GCLK     (GCLK),
    .reset    (reset),
    .we       (tbl_we),
    .waddr    (tbl_addr),
    .pinc1    (tbl_pinc1),
    .pinc2    (tbl_pinc2),
    .dwell    (tbl_dwell),
    .re       (rd_en),
    .raddr    (cur_idx_q),
    .rd_pinc1 (cfg1_tdata),
    .rd_pinc2 (cfg2_tdata),
    .rd_dwell (rd_dwell)
  );

  always_ff @(posedge GCLK or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cur_idx_q    <= '0;
      last_idx_q   <= '0;
      tvalid1_q    <= 1'b0;
      tvalid2_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      settle_q     <= '0;
      dwell_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_idx_q    <= cur_idx_d;
      last_idx_q   <= last_idx_d;
      tvalid1_q    <= tvalid1_d;
      tvalid2_q    <= tvalid2_d;
      abort_pend_q <= abort_pend_d;
      settle_q     <= settle_d;
      dwell_q      <= dwell_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_idx_d    = cur_idx_q;
    last_idx_d   = last_idx_q;
    tvalid1_d    = tvalid1_q;
    tvalid2_d    = tvalid2_q;
    abort_pend_d = abort_pend_q;
    settle_d     = settle_q;
    dwell_d      = dwell_q;
    rd_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort && (num_entries != '0) && (num_entries <= MaxEntries)) begin
          last_idx_d = IdxW'(num_entries - 1'b1);
          cur_idx_d  = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          rd_en        = 1'b1;
          tvalid1_d    = 1'b1;
          tvalid2_d    = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = StCfg;
        end
      end
      StCfg: begin
        // Each channel retires independently; abort only takes effect once both have.
        if (cfg1_tready) tvalid1_d = 1'b0;
        if (cfg2_tready) tvalid2_d = 1'b0;
        if (abort) abort_pend_d = 1'b1;
        if (!tvalid1_d && !tvalid2_d) begin
          state_d      = (abort || abort_pend_q) ? StIdle : StSettle;
          settle_d     = SetW'(SETTLE_CYCLES);
          abort_pend_d = 1'b0;
        end
      end
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
        end else if (settle_q != '0) begin
          settle_d = settle_q - 1'b1;
        end else if (dds_valid) begin
          dwell_d = (rd_dwell == '0) ? DWELL_W'(1) : rd_dwell;
          state_d = StDwell;
        end
      end
      StDwell: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          if (dwell_q != '0) dwell_d = dwell_q - 1'b1;
          if (dwell_q <= DWELL_W'(1)) begin
            if (cur_idx_q != last_idx_q) begin
              cur_idx_d = cur_idx_q + 1'b1;
              state_d   = StLoad;
            end else if (loop_en) begin
              cur_idx_d = '0;
              state_d   = StLoad;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign cfg1_tvalid = tvalid1_q;
  assign cfg2_tvalid = tvalid2_q;
  assign MODULE_ENA  = (state_q == StDwell);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign cur_idx     = cur_idx_q;

endmodule

// File: tb/tb_dds_hop_sequencer.sv
// Bench for dds_hop_sequencer: directed scenarios plus randomized traffic, all
// compared each cycle against a behavioural model of the hop sequence.
module tb_dds_hop_sequencer;

  localparam int Settle = 16;
  localparam int PIdle = 0, PLoad = 1, PCfg = 2, PSettle = 3, PDwell = 4, PDone = 5;

  logic        GCLK;
  logic        reset;
  logic        tbl_we;
  logic [2:0]  tbl_addr;
  logic [31:0] tbl_pinc1, tbl_pinc2;
  logic [23:0] tbl_dwell;
  logic [3:0]  num_entries;
  logic        loop_en, start, abort;
  logic [31:0] cfg1_tdata, cfg2_tdata;
  logic        cfg1_tvalid, cfg2_tvalid, cfg1_tready, cfg2_tready;
  logic        dds_valid, MODULE_ENA, busy, done;
  logic [2:0]  cur_idx;

  int n_vec = 0;
  int n_mis = 0;

  dds_hop_sequencer dut (
    .GCLK        (GCLK),
    .reset       (reset),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_pinc1   (tbl_pinc1),
    .tbl_pinc2   (tbl_pinc2),
    .tbl_dwell   (tbl_dwell),
    .num_entries (num_entries),
    .loop_en     (loop_en),
    .start       (start),
    .abort       (abort),
    .cfg1_tdata  (cfg1_tdata),
    .cfg1_tvalid (cfg1_tvalid),
    .cfg1_tready (cfg1_tready),
    .cfg2_tdata  (cfg2_tdata),
    .cfg2_tvalid (cfg2_tvalid),
    .cfg2_tready (cfg2_tready),
    .dds_valid   (dds_valid),
    .MODULE_ENA  (MODULE_ENA),
    .busy        (busy),
    .done        (done),
    .cur_idx     (cur_idx)
  );

  initial GCLK = 1'b0;
  always #5 GCLK = ~GCLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          ph, m_n, m_idx, m_age, m_dw;
  logic        m_v1, m_v2, m_ab;
  logic [31:0] m_d1, m_d2;
  logic [31:0] t1 [8];
  logic [31:0] t2 [8];
  int          tdw [8];

  task automatic model_reset();
    ph = PIdle; m_n = 0; m_idx = 0; m_age = 0; m_dw = 0;
    m_v1 = 1'b0; m_v2 = 1'b0; m_ab = 1'b0; m_d1 = '0; m_d2 = '0;
    for (int i = 0; i < 8; i++) begin
      t1[i] = '0; t2[i] = '0; tdw[i] = 0;
    end
  endtask

  task automatic model_step();
    int cur;
    cur = ph;
    case (cur)
      PIdle: begin
        if (start && !abort && int'(num_entries) >= 1 && int'(num_entries) <= 8) begin
          m_n = int'(num_entries); m_idx = 0; ph = PLoad;
        end
      end
      PLoad: begin
        if (abort) ph = PIdle;
        else begin
          m_d1 = t1[m_idx]; m_d2 = t2[m_idx]; m_dw = tdw[m_idx];
          m_v1 = 1'b1; m_v2 = 1'b1; m_ab = 1'b0; ph = PCfg;
        end
      end
      PCfg: begin
        if (cfg1_tready) m_v1 = 1'b0;
        if (cfg2_tready) m_v2 = 1'b0;
        if (abort) m_ab = 1'b1;
        if (!m_v1 && !m_v2) begin
          ph = m_ab ? PIdle : PSettle;
          m_age = 0; m_ab = 1'b0;
        end
      end
      PSettle: begin
        if (abort) ph = PIdle;
        else if (m_age >= Settle && dds_valid) begin ph = PDwell; m_age = 0; end
        else m_age++;
      end
      PDwell: begin
        if (abort) ph = PIdle;
        else begin
          m_age++;
          if (m_age >= ((m_dw == 0) ? 1 : m_dw)) begin
            if (m_idx < m_n - 1) begin m_idx++; ph = PLoad; end
            else if (loop_en) begin m_idx = 0; ph = PLoad; end
            else ph = PDone;
          end
        end
      end
      default: ph = PIdle;
    endcase
    // Table write lands after the LOAD read of the same edge.
    if (tbl_we) begin
      t1[tbl_addr] = tbl_pinc1; t2[tbl_addr] = tbl_pinc2; tdw[tbl_addr] = int'(tbl_dwell);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge GCLK or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge GCLK);
      chk("busy", busy, ph != PIdle);
      chk("module_ena", MODULE_ENA, ph == PDwell);
      chk("done", done, ph == PDone);
      chk("cur_idx", cur_idx, m_idx);
      chk("cfg1_tvalid", cfg1_tvalid, m_v1);
      chk("cfg2_tvalid", cfg2_tvalid, m_v2);
      chk("cfg1_tdata", cfg1_tdata, m_d1);
      chk("cfg2_tdata", cfg2_tdata, m_d2);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic cond(input int sel);
    case (sel)
      0:       return !busy;
      1:       return cfg1_tvalid;
      2:       return MODULE_ENA;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_until(input string nm, input int sel, input int budget);
    int k;
    k = 0;
    while (!cond(sel) && k < budget) begin
      @(negedge GCLK);
      k++;
    end
    if (!cond(sel)) begin
      n_vec++; n_mis++;
      $display("FAIL %s: condition false after %0d cycles, expected true", nm, budget);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] p1, input logic [31:0] p2, input int dw);
    @(negedge GCLK);
    tbl_we = 1'b1; tbl_addr = 3'(a); tbl_pinc1 = p1; tbl_pinc2 = p2; tbl_dwell = 24'(dw);
    @(negedge GCLK);
    tbl_we = 1'b0;
  endtask

  task automatic pulse_start(input int n);
    @(negedge GCLK);
    num_entries = 4'(n); start = 1'b1;
    @(negedge GCLK);
    start = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int runs[$];
    int run, dones, loads, ena_hi;
    logic prev_v1;

    reset = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_pinc1 = '0; tbl_pinc2 = '0;
    tbl_dwell = '0; num_entries = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
    cfg1_tready = 1'b1; cfg2_tready = 1'b1; dds_valid = 1'b1;
    repeat (3) @(negedge GCLK);
    chk("reset_busy", busy, 0);
    chk("reset_cfg1_tvalid", cfg1_tvalid, 0);
    reset = 1'b1;

    // Two-entry run, no loop.
    wr(0, 32'h0100_0000, 32'h0200_0000, 5);
    wr(1, 32'h0300_0000, 32'h0400_0000, 3);
    pulse_start(2);
    run = 0; dones = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge GCLK);
      if (MODULE_ENA) run++;
      else if (run != 0) begin runs.push_back(run); run = 0; end
      if (done) dones++;
      if (!busy) break;
    end
    chk("run_count", runs.size(), 2);
    chk("dwell_entry0", (runs.size() > 0) ? runs[0] : 0, 5);
    chk("dwell_entry1", (runs.size() > 1) ? runs[1] : 0, 3);
    chk("done_pulses", dones, 1);
    chk("idle_after_run", busy, 0);

    // cfg2 back-pressure for 10 cycles.
    cfg2_tready = 1'b0;
    pulse_start(1);
    wait_until("bp_cfg_start", 1, 10);
    for (int k = 0; k < 10; k++) begin
      chk("bp_cfg2_tvalid", cfg2_tvalid, 1);
      chk("bp_cfg2_tdata", cfg2_tdata, 32'h0200_0000);
      chk("bp_cfg1_tvalid", cfg1_tvalid, (k == 0) ? 1 : 0);
      chk("bp_no_ena", MODULE_ENA, 0);
      @(negedge GCLK);
    end
    cfg2_tready = 1'b1;
    wait_until("bp_idle", 0, 200);

    // dds_valid withheld after configuration.
    dds_valid = 1'b0;
    pulse_start(1);
    wait_until("dv_cfg", 1, 10);
    ena_hi = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge GCLK);
      if (MODULE_ENA) ena_hi++;
    end
    chk("dv_low_no_ena", ena_hi, 0);
    dds_valid = 1'b1;
    @(negedge GCLK);
    chk("dv_rise_ena", MODULE_ENA, 1);
    wait_until("dv_idle", 0, 200);

    // Looping single entry, then abort while dwelling.
    loop_en = 1'b1;
    pulse_start(1);
    loads = 0; dones = 0; prev_v1 = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge GCLK);
      if (cfg1_tvalid && !prev_v1) loads++;
      prev_v1 = cfg1_tvalid;
      if (done) dones++;
    end
    chk("loop_reloads_ge3", loads >= 3, 1);
    chk("loop_no_done", dones, 0);
    wait_until("loop_dwell", 2, 100);
    abort = 1'b1;
    @(negedge GCLK);
    abort = 1'b0;
    chk("abort_dwell_busy", busy, 0);
    chk("abort_dwell_ena", MODULE_ENA, 0);
    loop_en = 1'b0;

    // Abort in CFG with readys low: handshakes must still complete.
    cfg1_tready = 1'b0; cfg2_tready = 1'b0;
    pulse_start(1);
    wait_until("acfg_start", 1, 10);
    abort = 1'b1;
    @(negedge GCLK);
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("acfg_hold_v1", cfg1_tvalid, 1);
      chk("acfg_hold_v2", cfg2_tvalid, 1);
      @(negedge GCLK);
    end
    cfg1_tready = 1'b1; cfg2_tready = 1'b1;
    @(negedge GCLK);
    chk("acfg_idle", busy, 0);
    chk("acfg_v1_off", cfg1_tvalid, 0);

    // Illegal lengths and start+abort are ignored.
    pulse_start(0);
    chk("start_n0_ignored", busy, 0);
    pulse_start(9);
    chk("start_n9_ignored", busy, 0);
    @(negedge GCLK);
    num_entries = 4'd1; start = 1'b1; abort = 1'b1;
    @(negedge GCLK);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_ignored", busy, 0);

    // Asynchronous reset during DWELL.
    loop_en = 1'b1;
    pulse_start(1);
    wait_until("rst_dwell", 2, 100);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ena", MODULE_ENA, 0);
    chk("arst_done", done, 0);
    chk("arst_idx", cur_idx, 0);
    chk("arst_v1", cfg1_tvalid, 0);
    chk("arst_v2", cfg2_tvalid, 0);
    chk("arst_d1", cfg1_tdata, 0);
    chk("arst_d2", cfg2_tdata, 0);
    @(negedge GCLK);
    reset = 1'b1;
    loop_en = 1'b0;
    pulse_start(1);
    wait_until("clr_cfg", 1, 10);
    chk("cleared_d1", cfg1_tdata, 0);
    chk("cleared_d2", cfg2_tdata, 0);
    ena_hi = 0;
    for (int k = 0; k < 100 && busy; k++) begin
      @(negedge GCLK);
      if (MODULE_ENA) ena_hi++;
    end
    chk("dwell0_as_1", ena_hi, 1);

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      @(negedge GCLK);
      cfg1_tready = ($urandom_range(0, 3) != 0);
      cfg2_tready = ($urandom_range(0, 3) != 0);
      dds_valid   = ($urandom_range(0, 3) != 0);
      abort       = ($urandom_range(0, 59) == 0);
      start       = ($urandom_range(0, 9) == 0);
      num_entries = 4'($urandom_range(0, 9));
      loop_en     = ($urandom_range(0, 2) == 0);
      tbl_we      = ($urandom_range(0, 4) == 0);
      tbl_addr    = 3'($urandom_range(0, 7));
      tbl_pinc1   = $urandom;
      tbl_pinc2   = $urandom;
      tbl_dwell   = 24'($urandom_range(0, 6));
    end
    @(negedge GCLK);
    start = 1'b0; abort = 1'b0; tbl_we = 1'b0;
    repeat (2) @(negedge GCLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
